// File: rtl/param_regfile_pkg.sv
// Shared defaults for the parametrised register file.
// Widths, default reset image and read-mode selectors.
package param_regfile_pkg;

    localparam int REGF_WIDTH      = 8;
    localparam int REGF_DEPTH      = 16;
    localparam int REGF_ADDR_W     = 4;
    localparam int REGF_NUM_EXPORT = 4;

    // reg3 = 8'h08, reg2 = 8'h21, everything else zero
    localparam logic [REGF_DEPTH*REGF_WIDTH-1:0] REGF_DEF_RESET_VALS =
        {{(REGF_DEPTH-4){8'h00}}, 8'h08, 8'h21, 8'h00, 8'h00};

    localparam bit REGF_RD_OLD = 1'b0;
    localparam bit REGF_RD_NEW = 1'b1;

endpackage

// File: rtl/param_regfile.sv
// Parametrised register file with reset image, read-only mask,
// registered read/valid/error pulses, soft clear and update strobes.
module param_regfile
    import param_regfile_pkg::*;
#(
    parameter int WIDTH      = REGF_WIDTH,
    parameter int DEPTH      = REGF_DEPTH,
    parameter int ADDR_W     = REGF_ADDR_W,
    parameter int NUM_EXPORT = REGF_NUM_EXPORT,
    parameter logic [DEPTH*WIDTH-1:0] RESET_VALS =
        (DEPTH*WIDTH)'(REGF_DEF_RESET_VALS),
    parameter logic [DEPTH-1:0] RO_MASK = '0,
    parameter bit RD_MODE = REGF_RD_OLD
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [WIDTH-1:0]            i_data,
    input  logic [ADDR_W-1:0]           i_add,
    input  logic                        i_en_w,
    input  logic                        i_en_r,
    input  logic                        i_clr,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_valid,
    output logic                        o_rd_err,
    output logic                        o_wr_err,
    output logic [NUM_EXPORT*WIDTH-1:0] o_regs,
    output logic [NUM_EXPORT-1:0]       o_upd
);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [WIDTH-1:0]      data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  rd_err_q, rd_err_d;
    logic                  wr_err_q, wr_err_d;
    logic [NUM_EXPORT-1:0] upd_q, upd_d;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [WIDTH-1:0]      rd_word;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    function automatic logic wr_accept(
        input logic [ADDR_W-1:0] a,
        input logic              en,
        input logic              clr
    );
        return en && !clr && in_range(a) && !RO_MASK[a];
    endfunction

    always_comb begin
        wr_ok = wr_accept(i_add, i_en_w, i_clr);
        rd_ok = in_range(i_add);

        mem_d = mem_q;
        if (i_clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_d[k] = RESET_VALS[k*WIDTH +: WIDTH];
            end
        end else if (wr_ok) begin
            mem_d[i_add] = i_data;
        end

        // wr_ok is already false under clear, so bypass never applies there
        rd_word = '0;
        if (rd_ok) begin
            if (RD_MODE == REGF_RD_NEW && wr_ok) begin
                rd_word = i_data;
            end else begin
                rd_word = mem_q[i_add];
            end
        end

        data_d   = i_en_r ? rd_word : data_q;
        valid_d  = i_en_r;
        rd_err_d = i_en_r && !rd_ok;
        wr_err_d = i_en_w && !i_clr && !wr_ok;

        upd_d = '0;
        for (int k = 0; k < NUM_EXPORT; k++) begin
            upd_d[k] = !RO_MASK[k] &&
                       (i_clr || (wr_ok && int'(i_add) == k));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= RESET_VALS[k*WIDTH +: WIDTH];
            end
            data_q   <= '0;
            valid_q  <= 1'b0;
            rd_err_q <= 1'b0;
            wr_err_q <= 1'b0;
            upd_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            rd_err_q <= rd_err_d;
            wr_err_q <= wr_err_d;
            upd_q    <= upd_d;
        end
    end

    for (genvar g = 0; g < NUM_EXPORT; g++) begin : g_exp
        assign o_regs[g*WIDTH +: WIDTH] = mem_q[g];
    end

    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_rd_err = rd_err_q;
    assign o_wr_err = wr_err_q;
    assign o_upd    = upd_q;

endmodule

// File: tb/tb_param_regfile.sv
// Randomised + directed bench for param_regfile, two configurations
// sharing one stimulus stream against a behavioural model.
module tb_param_regfile;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [7:0] i_data = '0;
    logic [3:0] i_add = '0;
    logic       i_en_w = 1'b0;
    logic       i_en_r = 1'b0;
    logic       i_clr = 1'b0;

    logic [7:0]  o_data   [2];
    logic        o_valid  [2];
    logic        o_rd_err [2];
    logic        o_wr_err [2];
    logic [31:0] o_regs   [2];
    logic [3:0]  o_upd    [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 i_clk = ~i_clk;

    // dut 0: 12 regs, reg2 read-only, read-old
    param_regfile #(
        .DEPTH(12), .RO_MASK(12'b0000_0000_0100), .RD_MODE(1'b0)
    ) dut0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_add(i_add),
        .i_en_w(i_en_w), .i_en_r(i_en_r), .i_clr(i_clr),
        .o_data(o_data[0]), .o_valid(o_valid[0]),
        .o_rd_err(o_rd_err[0]), .o_wr_err(o_wr_err[0]),
        .o_regs(o_regs[0]), .o_upd(o_upd[0])
    );

    // dut 1: 16 regs, nothing read-only, write-first
    param_regfile #(
        .RD_MODE(1'b1)
    ) dut1 (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_add(i_add),
        .i_en_w(i_en_w), .i_en_r(i_en_r), .i_clr(i_clr),
        .o_data(o_data[1]), .o_valid(o_valid[1]),
        .o_rd_err(o_rd_err[1]), .o_wr_err(o_wr_err[1]),
        .o_regs(o_regs[1]), .o_upd(o_upd[1])
    );

    int         dep [2] = '{12, 16};
    bit [15:0]  ro  [2] = '{16'h0004, 16'h0000};
    bit         rdm [2] = '{1'b0, 1'b1};

    logic [7:0] m_mem   [2][16];
    logic [7:0] e_data  [2];
    logic       e_valid [2];
    logic       e_rderr [2];
    logic       e_wrerr [2];
    logic [3:0] e_upd   [2];

    function automatic logic [7:0] rv(input int k);
        return (k == 2) ? 8'h21 : (k == 3) ? 8'h08 : 8'h00;
    endfunction

    always @(posedge i_clk or negedge i_rst) begin
        for (int d = 0; d < 2; d++) begin
            if (!i_rst) begin
                for (int k = 0; k < 16; k++) m_mem[d][k] = rv(k);
                e_data[d] = 0; e_valid[d] = 0;
                e_rderr[d] = 0; e_wrerr[d] = 0; e_upd[d] = 0;
            end else begin
                bit inr, acc;
                inr = int'(i_add) < dep[d];
                acc = i_en_w && inr && !ro[d][i_add] && !i_clr;
                if (i_en_r) begin
                    if (!inr) e_data[d] = 0;
                    else if (rdm[d] && acc) e_data[d] = i_data;
                    else e_data[d] = m_mem[d][i_add];
                end
                e_valid[d] = i_en_r;
                e_rderr[d] = i_en_r && !inr;
                e_wrerr[d] = i_en_w && !i_clr && !acc;
                for (int k = 0; k < 4; k++)
                    e_upd[d][k] = !ro[d][k] &&
                                  (i_clr || (acc && int'(i_add) == k));
                if (i_clr) begin
                    for (int k = 0; k < 16; k++) m_mem[d][k] = rv(k);
                end else if (acc) begin
                    m_mem[d][i_add] = i_data;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d data", d), 32'(o_data[d]),
                      32'(e_data[d]));
                check($sformatf("d%0d valid", d), 32'(o_valid[d]),
                      32'(e_valid[d]));
                check($sformatf("d%0d rderr", d), 32'(o_rd_err[d]),
                      32'(e_rderr[d]));
                check($sformatf("d%0d wrerr", d), 32'(o_wr_err[d]),
                      32'(e_wrerr[d]));
                check($sformatf("d%0d regs", d), o_regs[d],
                      {m_mem[d][3], m_mem[d][2], m_mem[d][1], m_mem[d][0]});
                check($sformatf("d%0d upd", d), 32'(o_upd[d]),
                      32'(e_upd[d]));
            end
        end
    end

    task automatic cyc(input bit w, input bit r, input bit c,
                       input logic [3:0] a, input logic [7:0] dt);
        @(negedge i_clk);
        i_en_w = w; i_en_r = r; i_clr = c; i_add = a; i_data = dt;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst regs0", o_regs[0], 32'h0821_0000);
        check("rst regs1", o_regs[1], 32'h0821_0000);
        check("rst data", 32'(o_data[0]), 32'h0);
        check("rst valid", 32'(o_valid[0]), 32'h0);
        @(negedge i_clk);
        i_rst = 1'b1;
        chk_en = 1'b1;

        cyc(0, 1, 0, 4'd0, 8'h00);
        check("rd0", 32'(o_data[0]), 32'h00);
        check("rd0 valid", 32'(o_valid[0]), 32'h1);
        cyc(0, 1, 0, 4'd2, 8'h00);
        check("rd2", 32'(o_data[0]), 32'h21);
        cyc(0, 1, 0, 4'd3, 8'h00);
        check("rd3", 32'(o_data[1]), 32'h08);

        cyc(1, 0, 0, 4'd1, 8'hA5);
        check("wr1 regs", o_regs[0], 32'h0821_A500);
        check("wr1 upd", 32'(o_upd[0]), 32'b0010);
        check("rd3 valid fall", 32'(o_valid[0]), 32'h0);
        cyc(0, 1, 0, 4'd1, 8'h00);
        check("rd1", 32'(o_data[0]), 32'hA5);

        cyc(1, 0, 0, 4'd2, 8'hFF);
        check("ro wrerr", 32'(o_wr_err[0]), 32'h1);
        check("ro keep", 32'(o_regs[0][23:16]), 32'h21);
        check("ro upd", 32'(o_upd[0]), 32'h0);
        check("d1 wr2", 32'(o_regs[1][23:16]), 32'hFF);
        cyc(0, 0, 0, 4'd0, 8'h00);
        check("wrerr pulse", 32'(o_wr_err[0]), 32'h0);

        cyc(0, 1, 0, 4'd14, 8'h00);
        check("oor data", 32'(o_data[0]), 32'h0);
        check("oor valid", 32'(o_valid[0]), 32'h1);
        check("oor rderr", 32'(o_rd_err[0]), 32'h1);
        check("d1 no rderr", 32'(o_rd_err[1]), 32'h0);
        cyc(1, 0, 0, 4'd13, 8'h55);
        check("oor wrerr", 32'(o_wr_err[0]), 32'h1);

        cyc(1, 0, 0, 4'd5, 8'h3C);
        cyc(1, 1, 0, 4'd5, 8'h77);
        check("rd old", 32'(o_data[0]), 32'h3C);
        check("rd new", 32'(o_data[1]), 32'h77);
        cyc(0, 1, 0, 4'd5, 8'h00);
        check("reg5 d0", 32'(o_data[0]), 32'h77);
        check("reg5 d1", 32'(o_data[1]), 32'h77);

        for (int k = 0; k < 4; k++)
            cyc(1, 0, 0, 4'(k), 8'(8'h11 * (k + 1)));
        cyc(1, 1, 1, 4'd3, 8'h99);
        check("clr rd d0", 32'(o_data[0]), 32'h44);
        check("clr rd d1", 32'(o_data[1]), 32'h44);
        check("clr regs", o_regs[1], 32'h0821_0000);
        check("clr upd d1", 32'(o_upd[1]), 32'b1111);
        check("clr upd d0", 32'(o_upd[0]), 32'b1011);
        check("clr no err", 32'(o_wr_err[1]), 32'h0);

        for (int n = 0; n < 3000; n++) begin
            @(negedge i_clk);
            i_en_w = ($urandom_range(0, 1) == 1);
            i_en_r = ($urandom_range(0, 1) == 1);
            i_clr  = ($urandom_range(0, 19) == 0);
            i_add  = 4'($urandom_range(0, 15));
            i_data = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #2 i_rst = 1'b0;
                @(negedge i_clk);
                #2 i_rst = 1'b1;
            end
        end

        cyc(1, 0, 0, 4'd0, 8'hC3);
        cyc(0, 1, 0, 4'd3, 8'h00);
        @(negedge i_clk);
        i_en_w = 0; i_en_r = 1; i_add = 4'd2;
        #2 i_rst = 1'b0;
        #1;
        check("mid rst valid", 32'(o_valid[0]), 32'h0);
        check("mid rst regs", o_regs[0], 32'h0821_0000);
        @(negedge i_clk);
        i_en_r = 0;
        #2 i_rst = 1'b1;
        cyc(0, 0, 0, 4'd0, 8'h00);
        check("post rst valid", 32'(o_valid[1]), 32'h0);
        check("post rst data", 32'(o_data[1]), 32'h0);

        @(negedge i_clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
